block_mover: RTL and testbench

- Initiator side of the move-check handshake. Owns the falling block's position (b_x, b_y) and rotation.
- Accepts one move command at a time from game control. Launches the move checker with a one-cycle run pulse, waits for its done pulse, then commits or discards the move.
- Reports the outcome to game control, including landing (a down move is blocked) and game over (the appear position is blocked).

---
 rtl/block_mover.sv | 189 ++++++++++++++++++
 tb/tb_block_mover.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_mover.sv
// block_mover: initiator side of the move-check handshake.
// Holds the falling block's position (b_x, b_y) and rotation. It accepts one
// move command at a time, starts the move checker with a one-cycle run pulse,
// waits for the checker's done pulse, then commits or discards the move.
// A timeout guards against a checker that never answers.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   move_req_valid/ready/move_req command handshake from game control
//   chk_run, chk_req_move         checker start pulse and command under test
//   chk_done, chk_can_move        checker completion and verdict
//   chk_move_x, chk_move_y        signed 2-bit offsets applied on commit
//   b_x, b_y, b_rotation          block state (signed position)
//   resp_valid/ok/err             one-cycle outcome pulse to game control
//   landed, game_over             rejected DOWN / rejected APPEAR indications
module block_mover #(
  parameter int COL_W   = 4,
  parameter int ROW_W   = 5,
  parameter int SPAWN_X = 3,
  parameter int SPAWN_Y = 0,
  parameter int TIMEOUT = 63
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    move_req_valid,
  input  logic [2:0]              move_req,
  output logic                    move_req_ready,
  output logic                    chk_run,
  output logic [2:0]              chk_req_move,
  input  logic                    chk_done,
  input  logic                    chk_can_move,
  input  logic [1:0]              chk_move_x,
  input  logic [1:0]              chk_move_y,
  output logic signed [COL_W:0]   b_x,
  output logic signed [ROW_W:0]   b_y,
  output logic [1:0]              b_rotation,
  output logic                    resp_valid,
  output logic                    resp_ok,
  output logic                    resp_err,
  output logic                    landed,
  output logic                    game_over
);

  localparam logic [2:0] MOVE_LEFT   = 3'd1;
  localparam logic [2:0] MOVE_RIGHT  = 3'd2;
  localparam logic [2:0] MOVE_DOWN   = 3'd3;
  localparam logic [2:0] MOVE_ROTATE = 3'd4;
  localparam logic [2:0] MOVE_APPEAR = 3'd5;

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT);
  localparam logic signed [COL_W:0] SPAWN_X_VAL = (COL_W+1)'(SPAWN_X);
  localparam logic signed [ROW_W:0] SPAWN_Y_VAL = (ROW_W+1)'(SPAWN_Y);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic                    chk_run_q, chk_run_d;
  logic [2:0]              req_q, req_d;
  logic signed [COL_W:0]   b_x_q, b_x_d;
  logic signed [ROW_W:0]   b_y_q, b_y_d;
  logic [1:0]              rot_q, rot_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    resp_ok_q, resp_ok_d;
  logic                    resp_err_q, resp_err_d;
  logic                    landed_q, landed_d;
  logic                    game_over_q, game_over_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    req_legal;
  logic signed [COL_W:0]   dx;
  logic signed [ROW_W:0]   dy;

  assign req_legal = move_req inside {MOVE_LEFT, MOVE_RIGHT, MOVE_DOWN,
                                      MOVE_ROTATE, MOVE_APPEAR};
  assign dx = {{(COL_W-1){chk_move_x[1]}}, chk_move_x};
  assign dy = {{(ROW_W-1){chk_move_y[1]}}, chk_move_y};

  always_comb begin
    state_d      = state_q;
    chk_run_d    = 1'b0;
    req_d        = req_q;
    b_x_d        = b_x_q;
    b_y_d        = b_y_q;
    rot_d        = rot_q;
    resp_valid_d = 1'b0;
    resp_ok_d    = 1'b0;
    resp_err_d   = 1'b0;
    landed_d     = 1'b0;
    game_over_d  = 1'b0;
    cnt_d        = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (move_req_valid) begin
          req_d = move_req;
          if (req_legal) begin
            state_d   = S_RUN;
            chk_run_d = 1'b1;
            if (move_req == MOVE_APPEAR) begin
              b_x_d = SPAWN_X_VAL;
              b_y_d = SPAWN_Y_VAL;
              rot_d = '0;
            end
          end else begin
            // Illegal code bypasses the checker entirely.
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end
        end
      end
      S_RUN: begin
        // chk_done may still be asserted from a previous scan; ignore it here.
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (chk_done) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          if (chk_can_move) begin
            resp_ok_d = 1'b1;
            if (req_q != MOVE_APPEAR) begin
              b_x_d = b_x_q + dx;
              b_y_d = b_y_q + dy;
            end
            if (req_q == MOVE_ROTATE) rot_d = rot_q + 2'd1;
          end else begin
            landed_d    = (req_q == MOVE_DOWN);
            game_over_d = (req_q == MOVE_APPEAR);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == TIMEOUT_VAL) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      chk_run_q    <= 1'b0;
      req_q        <= '0;
      b_x_q        <= SPAWN_X_VAL;
      b_y_q        <= SPAWN_Y_VAL;
      rot_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_ok_q    <= 1'b0;
      resp_err_q   <= 1'b0;
      landed_q     <= 1'b0;
      game_over_q  <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      chk_run_q    <= chk_run_d;
      req_q        <= req_d;
      b_x_q        <= b_x_d;
      b_y_q        <= b_y_d;
      rot_q        <= rot_d;
      resp_valid_q <= resp_valid_d;
      resp_ok_q    <= resp_ok_d;
      resp_err_q   <= resp_err_d;
      landed_q     <= landed_d;
      game_over_q  <= game_over_d;
      cnt_q        <= cnt_d;
    end
  end

  assign move_req_ready = (state_q == S_IDLE);
  assign chk_run        = chk_run_q;
  assign chk_req_move   = req_q;
  assign b_x            = b_x_q;
  assign b_y            = b_y_q;
  assign b_rotation     = rot_q;
  assign resp_valid     = resp_valid_q;
  assign resp_ok        = resp_ok_q;
  assign resp_err       = resp_err_q;
  assign landed         = landed_q;
  assign game_over      = game_over_q;

endmodule

// File: tb/tb_block_mover.sv
// Self-checking bench for block_mover: directed scenarios plus randomized
// moves checked against a behavioural model of the block position.
module tb_block_mover;

  localparam int TIMEOUT = 63;
  localparam logic [2:0] M_LEFT = 3'd1, M_RIGHT = 3'd2, M_DOWN = 3'd3,
                         M_ROT = 3'd4, M_APPEAR = 3'd5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic move_req_valid = 1'b0;
  logic [2:0] move_req = '0;
  logic move_req_ready;
  logic chk_run;
  logic [2:0] chk_req_move;
  logic chk_done = 1'b0;
  logic chk_can_move = 1'b0;
  logic [1:0] chk_move_x = '0;
  logic [1:0] chk_move_y = '0;
  logic signed [4:0] b_x;
  logic signed [5:0] b_y;
  logic [1:0] b_rotation;
  logic resp_valid, resp_ok, resp_err, landed, game_over;

  int assertions = 0;
  int failures = 0;

  // Behavioural model of block state (kept as plain integers).
  int mbx = 3, mby = 0, mrot = 0;

  block_mover #(.COL_W(4), .ROW_W(5), .SPAWN_X(3), .SPAWN_Y(0), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .move_req_valid(move_req_valid), .move_req(move_req), .move_req_ready(move_req_ready),
    .chk_run(chk_run), .chk_req_move(chk_req_move), .chk_done(chk_done),
    .chk_can_move(chk_can_move), .chk_move_x(chk_move_x), .chk_move_y(chk_move_y),
    .b_x(b_x), .b_y(b_y), .b_rotation(b_rotation),
    .resp_valid(resp_valid), .resp_ok(resp_ok), .resp_err(resp_err),
    .landed(landed), .game_over(game_over)
  );

  always #5 clk = ~clk;

  function automatic int sx2(input logic [1:0] v);
    return v[1] ? int'(v) - 4 : int'(v);
  endfunction

  // Offers one command, plays the checker, and reports what was observed.
  // k counts cycles after the transfer edge (k=0 is the first cycle after it).
  task automatic run_move(input logic [2:0] code, input int delay, input bit give_done,
                          input bit can, input logic [1:0] mx, input logic [1:0] my,
                          input bit hold, input bit stale,
                          output int n_run, output int run_k, output int resp_k,
                          output bit ok, output bit err, output bit lnd, output bit gov,
                          output int viol, output int busy_rdy);
    n_run = 0; run_k = -1; resp_k = -1; ok = 0; err = 0; lnd = 0; gov = 0;
    viol = 0; busy_rdy = 0;
    for (int w = 0; w < 10 && !move_req_ready; w++) begin
      @(posedge clk); #1;
    end
    move_req = code;
    move_req_valid = 1'b1;
    @(posedge clk); #1;
    if (!hold) move_req_valid = 1'b0;
    for (int k = 0; k < 200; k++) begin
      chk_done = 1'b0;
      if (chk_run) begin
        n_run++;
        if (run_k < 0) run_k = k;
      end
      if (move_req_ready) busy_rdy++;
      if (resp_valid) begin
        ok = resp_ok; err = resp_err; lnd = landed; gov = game_over;
        resp_k = k;
        break;
      end
      if (resp_ok || resp_err || landed || game_over) viol++;
      if (chk_req_move !== code) viol++;
      if (stale && k == 0 && chk_run) begin
        chk_done = 1'b1; chk_can_move = ~can; chk_move_x = 2'b01; chk_move_y = 2'b01;
      end
      if (give_done && run_k >= 0 && k == run_k + 1 + delay) begin
        chk_done = 1'b1; chk_can_move = can; chk_move_x = mx; chk_move_y = my;
      end
      @(posedge clk); #1;
    end
    chk_done = 1'b0;
    move_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    assertions++;
    if (b_x !== 5'sd3 || b_y !== 6'sd0 || b_rotation !== 2'd0) begin
      failures++;
      $display("FAIL reset_pos: got x=%0d y=%0d r=%0d, want 3 0 0", b_x, b_y, b_rotation);
    end
    assertions++;
    if ({chk_run, chk_req_move, resp_valid, resp_ok, resp_err, landed, game_over} !== 9'd0) begin
      failures++;
      $display("FAIL reset_outs: got run=%b req=%0d rv=%b ok=%b err=%b l=%b go=%b, want all 0",
               chk_run, chk_req_move, resp_valid, resp_ok, resp_err, landed, game_over);
    end
    assertions++;
    if (move_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b want 1", move_req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    mbx = 3; mby = 0; mrot = 0;
  endtask

  task automatic test_appear();
    int n_run, run_k, resp_k, viol, br;
    bit ok, err, lnd, gov;
    run_move(M_APPEAR, 2, 1, 1, 2'b00, 2'b00, 0, 0, n_run, run_k, resp_k, ok, err, lnd, gov, viol, br);
    mbx = 3; mby = 0; mrot = 0;
    assertions++;
    if (ok !== 1'b1 || err !== 1'b0 || gov !== 1'b0) begin
      failures++;
      $display("FAIL appear_resp: got ok=%b err=%b go=%b want 1 0 0", ok, err, gov);
    end
    assertions++;
    if (n_run != 1 || run_k != 0 || resp_k != 4) begin
      failures++;
      $display("FAIL appear_timing: got runs=%0d run_k=%0d resp_k=%0d want 1 0 4", n_run, run_k, resp_k);
    end
    assertions++;
    if (b_x !== 5'sd3 || b_y !== 6'sd0 || b_rotation !== 2'd0 || viol != 0) begin
      failures++;
      $display("FAIL appear_state: got x=%0d y=%0d r=%0d viol=%0d want 3 0 0 0", b_x, b_y, b_rotation, viol);
    end
  endtask

  task automatic test_left();
    int n_run, run_k, resp_k, viol, br;
    bit ok, err, lnd, gov;
    run_move(M_LEFT, 0, 1, 1, 2'b11, 2'b00, 0, 0, n_run, run_k, resp_k, ok, err, lnd, gov, viol, br);
    assertions++;
    if (b_x !== 5'sd2 || ok !== 1'b1) begin
      failures++;
      $display("FAIL left_ok: got x=%0d ok=%b want 2 1", b_x, ok);
    end
    run_move(M_RIGHT, 1, 1, 1, 2'b01, 2'b00, 0, 0, n_run, run_k, resp_k, ok, err, lnd, gov, viol, br);
    run_move(M_LEFT, 3, 1, 0, 2'b11, 2'b00, 0, 0, n_run, run_k, resp_k, ok, err, lnd, gov, viol, br);
    assertions++;
    if (b_x !== 5'sd3 || ok !== 1'b0 || lnd !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL left_reject: got x=%0d ok=%b landed=%b err=%b want 3 0 0 0", b_x, ok, lnd, err);
    end
    mbx = 3;
  endtask

  task automatic test_down_land();
    int n_run, run_k, resp_k, viol, br;
    bit ok, err, lnd, gov;
    for (int i = 0; i < 18; i++)
      run_move(M_DOWN, 0, 1, 1, 2'b00, 2'b01, 0, 0, n_run, run_k, resp_k, ok, err, lnd, gov, viol, br);
    assertions++;
    if (b_y !== 6'sd18) begin
      failures++;
      $display("FAIL down_steps: got y=%0d want 18", b_y);
    end
    run_move(M_DOWN, 1, 1, 0, 2'b00, 2'b01, 0, 0, n_run, run_k, resp_k, ok, err, lnd, gov, viol, br);
    assertions++;
    if (b_y !== 6'sd18 || ok !== 1'b0 || lnd !== 1'b1 || gov !== 1'b0 || viol != 0) begin
      failures++;
      $display("FAIL down_land: got y=%0d ok=%b landed=%b go=%b viol=%0d want 18 0 1 0 0",
               b_y, ok, lnd, gov, viol);
    end
    mby = 18;
  endtask

  task automatic test_rotate_wrap();
    int n_run, run_k, resp_k, viol, br;
    bit ok, err, lnd, gov;
    for (int i = 0; i < 3; i++)
      run_move(M_ROT, 0, 1, 1, 2'b00, 2'b00, 0, 0, n_run, run_k, resp_k, ok, err, lnd, gov, viol, br);
    assertions++;
    if (b_rotation !== 2'd3) begin
      failures++;
      $display("FAIL rot_three: got %0d want 3", b_rotation);
    end
    run_move(M_ROT, 4, 1, 1, 2'b00, 2'b00, 1, 0, n_run, run_k, resp_k, ok, err, lnd, gov, viol, br);
    assertions++;
    if (b_rotation !== 2'd0 || ok !== 1'b1) begin
      failures++;
      $display("FAIL rot_wrap: got r=%0d ok=%b want 0 1", b_rotation, ok);
    end
    assertions++;
    if (n_run != 1 || br != 0 || resp_k != 6) begin
      failures++;
      $display("FAIL rot_hold_valid: got runs=%0d ready_busy=%0d resp_k=%0d want 1 0 6", n_run, br, resp_k);
    end
    mrot = 0;
  endtask

  task automatic test_timeout();
    int n_run, run_k, resp_k, viol, br;
    bit ok, err, lnd, gov;
    run_move(M_RIGHT, 0, 0, 1, 2'b01, 2'b00, 0, 0, n_run, run_k, resp_k, ok, err, lnd, gov, viol, br);
    assertions++;
    if (resp_k - run_k != TIMEOUT + 1 || run_k != 0) begin
      failures++;
      $display("FAIL timeout_latency: got run_k=%0d resp_k=%0d want 0 %0d", run_k, resp_k, TIMEOUT + 1);
    end
    assertions++;
    if (err !== 1'b1 || ok !== 1'b0 || b_x !== mbx[4:0] || b_y !== mby[5:0]) begin
      failures++;
      $display("FAIL timeout_state: got err=%b ok=%b x=%0d y=%0d want 1 0 %0d %0d", err, ok, b_x, b_y, mbx, mby);
    end
  endtask

  task automatic test_illegal();
    int n_run, run_k, resp_k, viol, br;
    bit ok, err, lnd, gov;
    logic [2:0] codes [3];
    codes[0] = 3'b111; codes[1] = 3'b000; codes[2] = 3'b110;
    for (int i = 0; i < 3; i++) begin
      run_move(codes[i], 0, 1, 1, 2'b01, 2'b01, 0, 0, n_run, run_k, resp_k, ok, err, lnd, gov, viol, br);
      assertions++;
      if (err !== 1'b1 || ok !== 1'b0 || n_run != 0 || resp_k != 0 || b_x !== mbx[4:0]) begin
        failures++;
        $display("FAIL illegal_%0d: got err=%b ok=%b runs=%0d resp_k=%0d x=%0d want 1 0 0 0 %0d",
                 codes[i], err, ok, n_run, resp_k, b_x, mbx);
      end
    end
  endtask

  task automatic test_random();
    int n_run, run_k, resp_k, viol, br, d;
    bit ok, err, lnd, gov, can, stale, legal;
    logic [2:0] code;
    logic [1:0] mx, my;
    bit e_ok, e_l, e_g;
    for (int i = 0; i < 60; i++) begin
      code = (i == 0) ? M_APPEAR : 3'($urandom_range(0, 7));
      can = ($urandom_range(0, 3) != 0);
      mx = 2'($urandom); my = 2'($urandom);
      d = $urandom_range(0, 5);
      stale = $urandom_range(0, 1);
      legal = (code >= 3'd1 && code <= 3'd5);
      run_move(code, d, 1, can, mx, my, 0, stale, n_run, run_k, resp_k, ok, err, lnd, gov, viol, br);
      e_ok = 0; e_l = 0; e_g = 0;
      if (legal) begin
        if (code == M_APPEAR) begin mbx = 3; mby = 0; mrot = 0; end
        if (can) begin
          e_ok = 1;
          if (code != M_APPEAR) begin
            mbx = (mbx + sx2(mx)) & 31;
            mby = (mby + sx2(my)) & 63;
          end
          if (code == M_ROT) mrot = (mrot + 1) % 4;
        end else begin
          e_l = (code == M_DOWN);
          e_g = (code == M_APPEAR);
        end
      end
      assertions++;
      if (b_x !== mbx[4:0] || b_y !== mby[5:0] || b_rotation !== mrot[1:0]) begin
        failures++;
        $display("FAIL rand_state[%0d] code=%0d: got x=%0d y=%0d r=%0d want %0d %0d %0d",
                 i, code, b_x, b_y, b_rotation, $signed(mbx[4:0]), $signed(mby[5:0]), mrot);
      end
      assertions++;
      if (ok !== e_ok || err !== !legal || lnd !== e_l || gov !== e_g) begin
        failures++;
        $display("FAIL rand_resp[%0d] code=%0d: got ok=%b err=%b l=%b go=%b want %b %b %b %b",
                 i, code, ok, err, lnd, gov, e_ok, !legal, e_l, e_g);
      end
      assertions++;
      if (n_run != (legal ? 1 : 0) || resp_k != (legal ? 2 + d : 0) || viol != 0 || br != 0) begin
        failures++;
        $display("FAIL rand_proto[%0d] code=%0d: got runs=%0d resp_k=%0d viol=%0d rdy=%0d want %0d %0d 0 0",
                 i, code, n_run, resp_k, viol, br, legal ? 1 : 0, legal ? 2 + d : 0);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n_run, run_k, resp_k, viol, br, bad;
    bit ok, err, lnd, gov;
    run_move(M_APPEAR, 0, 1, 1, 2'b00, 2'b00, 0, 0, n_run, run_k, resp_k, ok, err, lnd, gov, viol, br);
    run_move(M_RIGHT, 0, 1, 1, 2'b01, 2'b01, 0, 0, n_run, run_k, resp_k, ok, err, lnd, gov, viol, br);
    @(posedge clk); #1;
    move_req = M_LEFT; move_req_valid = 1'b1;
    @(posedge clk); #1;
    move_req_valid = 1'b0;
    @(posedge clk); #1;
    #3 rst_n = 1'b0;
    #1;
    assertions++;
    if (b_x !== 5'sd3 || b_y !== 6'sd0 || b_rotation !== 2'd0 || move_req_ready !== 1'b1 ||
        chk_req_move !== 3'd0 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_async: got x=%0d y=%0d r=%0d rdy=%b req=%0d rv=%b want 3 0 0 1 0 0",
               b_x, b_y, b_rotation, move_req_ready, chk_req_move, resp_valid);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    chk_done = 1'b1; chk_can_move = 1'b1; chk_move_x = 2'b01; chk_move_y = 2'b01;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk_done = 1'b0;
      if (resp_valid || chk_run || b_x !== 5'sd3 || b_y !== 6'sd0 || !move_req_ready) bad++;
    end
    assertions++;
    if (bad != 0) begin
      failures++;
      $display("FAIL reset_mid_late_done: got %0d bad cycles want 0", bad);
    end
    mbx = 3; mby = 0; mrot = 0;
  endtask

  initial begin
    fork
      begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
      end
    join_none
    test_reset();
    test_appear();
    test_left();
    test_down_land();
    test_rotate_wrap();
    test_timeout();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
